// File: rtl/pc_seq.sv
// pc_seq: multi-phase PC sequencer; jump/ertn/step commit at the last phase, a trap lands on the next edge.
// Latency: one instruction per NUM_PHASES cycles; stall freezes phase and PC while requests are still captured.
module pc_seq #(
  parameter int                   ADD_WIDTH  = 32,
  parameter logic [ADD_WIDTH-1:0] RESET_VEC  = 32'h1c000000,
  parameter logic [ADD_WIDTH-1:0] TRAP_VEC   = 32'h1c000100,
  parameter int                   STEP       = 4,
  parameter int                   NUM_PHASES = 5,
  parameter int                   ALIGN_BITS = 2,
  localparam int                  PH_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 stall,
  input  logic                 jump_en,
  input  logic [ADD_WIDTH-1:0] jump_target,
  input  logic                 trap_en,
  input  logic                 ertn_en,
  output logic [ADD_WIDTH-1:0] pc_out,
  output logic [PH_W-1:0]      phase,
  output logic                 instr_done,
  output logic [ADD_WIDTH-1:0] era_out,
  output logic                 misalign_err
);

  localparam logic [PH_W-1:0]      LAST_PH    = PH_W'(NUM_PHASES - 1);
  localparam logic [ADD_WIDTH-1:0] STEP_V     = ADD_WIDTH'(STEP);
  localparam logic [ADD_WIDTH-1:0] ALIGN_MASK = ADD_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic                 jmp_pend, jmp_pend_nxt;
  logic                 ert_pend, ert_pend_nxt;
  logic [ADD_WIDTH-1:0] jmp_tgt, jmp_tgt_nxt;
  logic [ADD_WIDTH-1:0] pc_nxt, era_nxt;
  logic [PH_W-1:0]      phase_nxt;
  logic                 mis_nxt;

  logic                 boundary;
  logic                 eff_ert;
  logic                 eff_jmp;
  logic [ADD_WIDTH-1:0] eff_tgt;
  logic                 tgt_misaligned;

  // A request raised in the boundary cycle itself is the newest one, so it beats the stored target.
  assign boundary       = (phase == LAST_PH) && !stall && !trap_en;
  assign eff_ert        = ert_pend | ertn_en;
  assign eff_jmp        = jmp_pend | jump_en;
  assign eff_tgt        = jump_en ? jump_target : jmp_tgt;
  assign tgt_misaligned = (eff_tgt & ALIGN_MASK) != '0;
  assign instr_done     = boundary;

  always_comb begin
    phase_nxt    = phase;
    pc_nxt       = pc_out;
    era_nxt      = era_out;
    jmp_pend_nxt = jmp_pend;
    jmp_tgt_nxt  = jmp_tgt;
    ert_pend_nxt = ert_pend;
    mis_nxt      = 1'b0;

    if (jump_en) begin
      jmp_pend_nxt = 1'b1;
      jmp_tgt_nxt  = jump_target;
    end
    if (ertn_en) begin
      ert_pend_nxt = 1'b1;
    end

    if (trap_en) begin
      pc_nxt       = TRAP_VEC;
      era_nxt      = pc_out;
      phase_nxt    = '0;
      jmp_pend_nxt = 1'b0;
      ert_pend_nxt = 1'b0;
    end else if (boundary) begin
      phase_nxt    = '0;
      jmp_pend_nxt = 1'b0;
      ert_pend_nxt = 1'b0;
      if (eff_ert) begin
        pc_nxt = era_out;
      end else if (eff_jmp && !tgt_misaligned) begin
        pc_nxt = eff_tgt;
      end else if (eff_jmp) begin
        // Misaligned target is handled as a trap, with a flag so software can tell the two apart.
        pc_nxt  = TRAP_VEC;
        era_nxt = pc_out;
        mis_nxt = 1'b1;
      end else begin
        pc_nxt = pc_out + STEP_V;
      end
    end else if (!stall) begin
      phase_nxt = phase + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_out       <= RESET_VEC;
      phase        <= '0;
      era_out      <= '0;
      misalign_err <= 1'b0;
      jmp_pend     <= 1'b0;
      jmp_tgt      <= '0;
      ert_pend     <= 1'b0;
    end else begin
      pc_out       <= pc_nxt;
      phase        <= phase_nxt;
      era_out      <= era_nxt;
      misalign_err <= mis_nxt;
      jmp_pend     <= jmp_pend_nxt;
      jmp_tgt      <= jmp_tgt_nxt;
      ert_pend     <= ert_pend_nxt;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: default 5-phase instance plus an 8-bit single-phase instance for wrap-around.
module tb_pc_seq;

  localparam logic [31:0] RV = 32'h1c000000;
  localparam logic [31:0] TV = 32'h1c000100;

  logic        clk;
  logic        rstn, stall, jump_en, trap_en, ertn_en;
  logic [31:0] jump_target, pc_out, era_out;
  logic [2:0]  phase;
  logic        instr_done, misalign_err;

  logic        rstn2, stall2, jump_en2, trap_en2, ertn_en2;
  logic [7:0]  jump_target2, pc_out2, era_out2;
  logic [0:0]  phase2;
  logic        instr_done2, misalign_err2;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  ph;
    logic [31:0] era;
    logic        mis;
  } st_t;

  st_t sb[$];

  pc_seq dut (
    .clk(clk), .rstn(rstn), .stall(stall), .jump_en(jump_en), .jump_target(jump_target),
    .trap_en(trap_en), .ertn_en(ertn_en), .pc_out(pc_out), .phase(phase),
    .instr_done(instr_done), .era_out(era_out), .misalign_err(misalign_err)
  );

  pc_seq #(
    .ADD_WIDTH(8), .RESET_VEC(8'hFC), .TRAP_VEC(8'h80), .STEP(4), .NUM_PHASES(1), .ALIGN_BITS(2)
  ) dut2 (
    .clk(clk), .rstn(rstn2), .stall(stall2), .jump_en(jump_en2), .jump_target(jump_target2),
    .trap_en(trap_en2), .ertn_en(ertn_en2), .pc_out(pc_out2), .phase(phase2),
    .instr_done(instr_done2), .era_out(era_out2), .misalign_err(misalign_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic st, input logic j, input logic [31:0] t, input logic tr, input logic er);
    stall = st; jump_en = j; jump_target = t; trap_en = tr; ertn_en = er;
  endtask

  task automatic test_reset();
    st_t o;
    set_in(0, 0, 32'h0, 0, 0);
    rstn = 1'b1;
    #3 rstn = 1'b0;
    #1;
    o = {pc_out, phase, era_out, misalign_err};
    n_cmp++;
    if (o !== st_t'{pc: RV, ph: 3'd0, era: 32'h0, mis: 1'b0}) begin
      n_fail++; $display("FAIL reset_state: got %h", o);
    end
    n_cmp++;
    if (instr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", instr_done); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_defaults();
    st_t e, o;
    for (int c = 0; c < 10; c++) begin
      set_in(0, 0, 32'h0, 0, 0);
      #1;
      n_cmp++;
      if (instr_done !== (c % 5 == 4)) begin n_fail++; $display("FAIL defaults_done c=%0d: got %b", c, instr_done); end
      sb.push_back(st_t'{pc: RV + 32'(4 * ((c + 1) / 5)), ph: 3'((c + 1) % 5), era: 32'h0, mis: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front(); o = {pc_out, phase, era_out, misalign_err};
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL defaults_state c=%0d: got %h want %h", c, o, e); end
    end
  endtask

  task automatic test_trap();
    st_t e, o;
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 32'h0, c == 2, 0);
      #1;
      n_cmp++;
      if (instr_done !== 1'b0) begin n_fail++; $display("FAIL trap_done c=%0d: got %b want 0", c, instr_done); end
      sb.push_back(st_t'{pc: (c == 2) ? TV : RV + 32'h8, ph: (c == 2) ? 3'd0 : 3'(c + 1),
                         era: (c == 2) ? RV + 32'h8 : 32'h0, mis: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front(); o = {pc_out, phase, era_out, misalign_err};
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL trap_state c=%0d: got %h want %h", c, o, e); end
    end
    for (int c = 0; c < 5; c++) begin
      set_in(0, 0, 32'h0, 0, c == 0);
      #1;
      n_cmp++;
      if (instr_done !== (c == 4)) begin n_fail++; $display("FAIL ertn_done c=%0d: got %b", c, instr_done); end
      sb.push_back(st_t'{pc: (c == 4) ? RV + 32'h8 : TV, ph: 3'((c + 1) % 5), era: RV + 32'h8, mis: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front(); o = {pc_out, phase, era_out, misalign_err};
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL ertn_state c=%0d: got %h want %h", c, o, e); end
    end
    // trap in the last phase with a jump pending: no commit, pending jump dropped
    for (int c = 0; c < 5; c++) begin
      set_in(0, c == 0, 32'h1c000200, c == 4, 0);
      #1;
      n_cmp++;
      if (instr_done !== 1'b0) begin n_fail++; $display("FAIL trap_last_done c=%0d: got %b want 0", c, instr_done); end
      sb.push_back(st_t'{pc: (c == 4) ? TV : RV + 32'h8, ph: 3'((c + 1) % 5), era: RV + 32'h8, mis: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front(); o = {pc_out, phase, era_out, misalign_err};
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL trap_last_state c=%0d: got %h want %h", c, o, e); end
    end
    for (int c = 0; c < 5; c++) begin
      set_in(0, 0, 32'h0, 0, 0);
      sb.push_back(st_t'{pc: (c == 4) ? TV + 32'h4 : TV, ph: 3'((c + 1) % 5), era: RV + 32'h8, mis: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front(); o = {pc_out, phase, era_out, misalign_err};
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL trap_clear_state c=%0d: got %h want %h", c, o, e); end
    end
  endtask

  task automatic test_jump();
    st_t e, o;
    // mid-instruction reset with an ertn pending: everything must return to reset values
    set_in(0, 0, 32'h0, 0, 1);
    @(posedge clk); #1;
    set_in(0, 0, 32'h0, 0, 0);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    o = {pc_out, phase, era_out, misalign_err};
    n_cmp++;
    if (o !== st_t'{pc: RV, ph: 3'd0, era: 32'h0, mis: 1'b0}) begin
      n_fail++; $display("FAIL midreset_state: got %h", o);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_in(0, (c == 1) || (c == 3), (c == 1) ? RV + 32'h40 : RV + 32'h80, 0, 0);
      #1;
      n_cmp++;
      if (instr_done !== (c == 4)) begin n_fail++; $display("FAIL jump_done c=%0d: got %b", c, instr_done); end
      sb.push_back(st_t'{pc: (c == 4) ? RV + 32'h80 : RV, ph: 3'((c + 1) % 5), era: 32'h0, mis: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front(); o = {pc_out, phase, era_out, misalign_err};
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL jump_state c=%0d: got %h want %h", c, o, e); end
    end
  endtask

  task automatic test_misalign();
    st_t e, o;
    for (int c = 0; c < 5; c++) begin
      set_in(0, c == 4, RV + 32'h42, 0, 0);
      #1;
      n_cmp++;
      if (instr_done !== (c == 4)) begin n_fail++; $display("FAIL misalign_done c=%0d: got %b", c, instr_done); end
      sb.push_back(st_t'{pc: (c == 4) ? TV : RV + 32'h80, ph: 3'((c + 1) % 5),
                         era: (c == 4) ? RV + 32'h80 : 32'h0, mis: (c == 4)});
      @(posedge clk); #1;
      e = sb.pop_front(); o = {pc_out, phase, era_out, misalign_err};
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL misalign_state c=%0d: got %h want %h", c, o, e); end
    end
    for (int c = 0; c < 5; c++) begin
      set_in(0, 0, 32'h0, 0, 0);
      sb.push_back(st_t'{pc: (c == 4) ? TV + 32'h4 : TV, ph: 3'((c + 1) % 5), era: RV + 32'h80, mis: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front(); o = {pc_out, phase, era_out, misalign_err};
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL misalign_after c=%0d: got %h want %h", c, o, e); end
    end
  endtask

  task automatic test_stall();
    st_t e, o;
    for (int c = 0; c < 8; c++) begin
      set_in((c >= 4) && (c <= 6), c == 5, RV + 32'h300, 0, 0);
      #1;
      n_cmp++;
      if (instr_done !== (c == 7)) begin n_fail++; $display("FAIL stall_done c=%0d: got %b", c, instr_done); end
      sb.push_back(st_t'{pc: (c == 7) ? RV + 32'h300 : TV + 32'h4,
                         ph: (c < 4) ? 3'(c + 1) : ((c < 7) ? 3'd4 : 3'd0),
                         era: RV + 32'h80, mis: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front(); o = {pc_out, phase, era_out, misalign_err};
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL stall_state c=%0d: got %h want %h", c, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    st_t e, o;
    // jump and ertn raised together in the boundary cycle: ertn wins, jump is discarded
    for (int c = 0; c < 10; c++) begin
      set_in(0, c == 4, RV + 32'h500, 0, c == 4);
      #1;
      n_cmp++;
      if (instr_done !== (c % 5 == 4)) begin n_fail++; $display("FAIL b2b_done c=%0d: got %b", c, instr_done); end
      sb.push_back(st_t'{pc: (c < 4) ? RV + 32'h300 : ((c < 9) ? RV + 32'h80 : RV + 32'h84),
                         ph: 3'((c + 1) % 5), era: RV + 32'h80, mis: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front(); o = {pc_out, phase, era_out, misalign_err};
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_state c=%0d: got %h want %h", c, o, e); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    n_cmp++;
    if ({pc_out2, phase2, era_out2, misalign_err2} !== {8'hFC, 1'b0, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL wrap_reset: got pc=%h ph=%b era=%h mis=%b", pc_out2, phase2, era_out2, misalign_err2);
    end
    rstn2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      e = (c == 0) ? 8'hFC : ((c == 1) ? 8'h00 : 8'h04);
      n_cmp++;
      if (pc_out2 !== e || phase2 !== 1'b0) begin
        n_fail++; $display("FAIL wrap_pc c=%0d: got %h ph=%b want %h ph=0", c, pc_out2, phase2, e);
      end
      n_cmp++;
      if (instr_done2 !== 1'b1) begin n_fail++; $display("FAIL wrap_done c=%0d: got %b want 1", c, instr_done2); end
      @(posedge clk); #1;
    end
    #2 rstn2 = 1'b0;
    #1;
    n_cmp++;
    if (pc_out2 !== 8'hFC) begin n_fail++; $display("FAIL wrap_async_reset: got %h want fc", pc_out2); end
  endtask

  initial begin
    rstn2 = 1'b0; stall2 = 1'b0; jump_en2 = 1'b0; jump_target2 = 8'h00; trap_en2 = 1'b0; ertn_en2 = 1'b0;
    test_reset();
    test_defaults();
    test_trap();
    test_jump();
    test_misalign();
    test_stall();
    test_back_to_back();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised multi-cycle program-counter sequencer; next generation of the core PC block.
- Owns its own instruction phase counter, so the control unit no longer drives a phase count.
- Redirect requests (jump, exception return, trap) may arrive in any phase. Jump and return are held pending and applied at the instruction boundary; a trap takes effect on the next clock edge.
- Adds stall, a misaligned-target check, and an exception return address register (ERA); sits between the control unit and instruction memory.

Parameters:
- ADD_WIDTH, 32, PC/address width in bits.
- RESET_VEC, 32'h1c000000, pc_out value after reset.
- TRAP_VEC, 32'h1c000100, pc_out value after a trap.
- STEP, 4, sequential increment per instruction.
- NUM_PHASES, 5, clock phases per instruction; must be >= 1.
- ALIGN_BITS, 2, low target bits that must be zero for a legal jump target.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- stall  in  1  freeze phase and PC.
- jump_en  in  1  jump request, any phase.
- jump_target  in  ADD_WIDTH  jump destination, valid with jump_en.
- trap_en  in  1  trap request, any phase.
- ertn_en  in  1  exception-return request, any phase.
- pc_out  out  ADD_WIDTH  current instruction address.
- phase  out  PH_W  current phase; PH_W = max(1, $clog2(NUM_PHASES)).
- instr_done  out  1  combinational; high when the PC commits this cycle.
- era_out  out  ADD_WIDTH  saved exception return address.
- misalign_err  out  1  registered one-cycle pulse on a misaligned redirect.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values, applied immediately on rstn low: pc_out=RESET_VEC, phase=0, era_out=0, misalign_err=0, all pending state cleared.
- Phase counter: counts 0..NUM_PHASES-1 and wraps to 0. It advances each cycle when stall=0 and holds when stall=1. With NUM_PHASES=1 every cycle is the last phase.
- Boundary definition: boundary = (phase==NUM_PHASES-1) && !stall && !trap_en.
- instr_done = boundary.
- Pending capture:
  - jump_en=1 in any cycle, stall included, sets jmp_pend and stores jump_target; the latest request wins.
  - ertn_en=1 sets ert_pend.
- Same-cycle bypass: a jump_en or ertn_en asserted in the boundary cycle participates in that cycle's commit.
- Commit at boundary, highest priority first:
  - ert_pend or ertn_en: pc_out <= era_out.
  - jmp_pend or jump_en with a legal target: pc_out <= target.
  - Jump target with nonzero low ALIGN_BITS bits: treated as a trap. pc_out <= TRAP_VEC, era_out <= pc_out, misalign_err=1 next cycle.
  - Otherwise: pc_out <= pc_out + STEP.
- After commit: pending state cleared, phase <= 0.
- Trap:
  - Trap priority: trap_en=1 in any phase overrides stall and the boundary.
  - Trap effect on the next edge: pc_out <= TRAP_VEC, era_out <= pc_out, phase <= 0, pending state cleared, misalign_err stays 0.
  - The instruction is aborted and instr_done stays low.
- Arithmetic: pc_out + STEP is modulo 2^ADD_WIDTH, so wrap-around at all-ones is legal. era_out changes only on a trap or misaligned redirect.
- Stall:
  - PC and phase hold.
  - Pending capture still occurs.
  - A stall released in the last phase commits on that cycle.
- Reset mid-instruction: phase, PC and pending state return to reset values asynchronously. The first post-reset instruction starts at phase 0.

Test Plan:
- Reset, then 10 cycles, no requests (defaults) -> pc_out 1c000000 for cycles 0-4, 1c000004 for cycles 5-9; instr_done high at phase 4 only.
- jump_en at phase 1, target 1c000040; jump_en at phase 3, target 1c000080 -> pc_out stays 1c000000 until the boundary, then 1c000080 (latest request wins).
- trap_en at phase 2 while pc_out=1c000008 -> next cycle pc_out=1c000100, era_out=1c000008, phase=0, instr_done never high. Then ertn_en at phase 0 -> after the boundary pc_out=1c000008.
- jump_en at phase 4, target 1c000042 (misaligned) -> pc_out=1c000100, era_out=old PC, misalign_err one-cycle pulse.
- stall held for 3 cycles at phase 4 with jump_en pulsed during the stall -> PC and phase frozen; on release, pc_out=jump target in that cycle's commit.
- ADD_WIDTH=8, RESET_VEC=8'hFC, STEP=4, NUM_PHASES=1 -> pc_out sequence FC, 00, 04; rstn asserted mid-cycle -> pc_out=FC immediately, without waiting for a clock edge.
